// File: rtl/aes_bcd_block_loader.sv
// Converts 3-digit BCD bytes to binary (sequential reverse double-dabble) and packs them MSB-first into an AES block.
// Optional macro AES_LOADER_RANGE_CHECK_EN: reject digits > 9 or values > 255 at accept and pulse err.
module aes_bcd_block_loader #(
   parameter int BYTES = 16,
   parameter int ITER  = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [11:0]        bcd_in,
   input  logic               bcd_valid,
   output logic               bcd_ready,
   input  logic               flush,
   output logic [8*BYTES-1:0] block_out,
   output logic               block_valid,
   input  logic               block_ready,
   output logic [4:0]         byte_count,
   output logic               err,
   output logic [1:0]         state_dbg
);

   localparam int IW = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, FULL = 2'd2} state_t;

   state_t         state, state_nxt;
   logic [19:0]    work, work_step;
   logic [IW-1:0]  iter;
   logic           accept, reject, take, last_iter, last_byte;

   // Handshake: a byte transfers on a rising edge where bcd_valid && bcd_ready.
   // The block transfers on a rising edge where block_valid && block_ready.
   assign bcd_ready   = (state == IDLE) && !flush;
   assign block_valid = (state == FULL);
   assign state_dbg   = state;
   assign accept      = bcd_valid && bcd_ready;
   assign take        = accept && !reject;
   assign last_iter   = (iter == IW'(ITER - 1));
   assign last_byte   = (byte_count == 5'(BYTES - 1));

`ifdef AES_LOADER_RANGE_CHECK_EN
   logic [3:0] d_h, d_t, d_o;
   logic       err_q;
   assign d_h = bcd_in[11:8];
   assign d_t = bcd_in[7:4];
   assign d_o = bcd_in[3:0];
   assign reject = (d_h > 4'd9) || (d_t > 4'd9) || (d_o > 4'd9) || (d_h > 4'd2) ||
                   ((d_h == 4'd2) && ((d_t > 4'd5) || ((d_t == 4'd5) && (d_o > 4'd5))));
   assign err = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= accept && reject;
   end
`else
   assign reject = 1'b0;
   assign err    = 1'b0;
`endif

   // One reverse double-dabble step: shift right, then correct each BCD digit >= 8.
   always_comb begin
      work_step = work >> 1;
      for (int d = 0; d < 3; d++) begin
         if (work_step[8+4*d +: 4] >= 4'd8)
            work_step[8+4*d +: 4] = work_step[8+4*d +: 4] - 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = CONV;
         CONV:    if (last_iter) state_nxt = last_byte ? FULL : IDLE;
         FULL:    if (block_ready || flush) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         work       <= '0;
         iter       <= '0;
         block_out  <= '0;
         byte_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  byte_count <= '0;
                  block_out  <= '0;
               end else if (take) begin
                  work <= {bcd_in, 8'h00};
                  iter <= '0;
               end
            end
            CONV: begin
               work <= work_step;
               iter <= iter + IW'(1);
               if (last_iter) begin
                  block_out  <= {block_out[8*BYTES-9:0], work_step[7:0]};
                  byte_count <= byte_count + 5'd1;
               end
            end
            FULL: begin
               // block_out is left as-is; it is overwritten byte by byte as the next block arrives.
               if (block_ready || flush) byte_count <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_bcd_block_loader.sv
// Scoreboard bench for aes_bcd_block_loader: expected bytes queued at drive time, popped as byte_count advances.
module tb_aes_bcd_block_loader;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [11:0]  bcd_in;
   logic         bcd_valid;
   logic         bcd_ready;
   logic         flush;
   logic [127:0] block_out;
   logic         block_valid;
   logic         block_ready;
   logic [4:0]   byte_count;
   logic         err;
   logic [1:0]   state_dbg;

   int           n_vec = 0;
   int           n_err = 0;
   int           cyc;
   logic [4:0]   prev_cnt = '0;
   logic [7:0]   exp_q[$];

   aes_bcd_block_loader dut (
      .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .bcd_ready(bcd_ready), .flush(flush), .block_out(block_out),
      .block_valid(block_valid), .block_ready(block_ready),
      .byte_count(byte_count), .err(err), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] h, t, o;
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      return {h, t, o};
   endfunction

   function automatic logic [7:0] exp_byte(input logic [11:0] b);
      int v;
      v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
      return 8'(v % 256);
   endfunction

   // driver: present a byte once bcd_ready is high, return at the negedge after the accept edge
   task automatic send(input logic [11:0] b, input bit stored);
      int n = 0;
      while (!bcd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 128'(bcd_ready), 128'd1);
      if (stored) exp_q.push_back(exp_byte(b));
      bcd_in    = b;
      bcd_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bcd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", 128'(bcd_ready), 128'd1);
   endtask

   task automatic send_wait(input logic [11:0] b);
      send(b, 1'b1);
      bcd_valid = 1'b0;
      wait_ready();
   endtask

   // scoreboard: each stored byte shows up as a +1 step of byte_count
   always @(negedge clk) begin
      if (reset_n && byte_count == prev_cnt + 5'd1) begin
         if (exp_q.size() == 0) check("sb_unexpected_byte", 128'(block_out[7:0]), 128'h100);
         else                   check("sb_byte", 128'(block_out[7:0]), 128'(exp_q.pop_front()));
      end
      prev_cnt = byte_count;
   end

   initial begin
      int n;
      logic [127:0] full_blk;
      logic [11:0]  b;
      full_blk    = 128'h00112233445566778899aabbccddeeff;
      reset_n     = 1'b0;
      flush       = 1'b0;
      bcd_valid   = 1'b0;
      bcd_in      = '0;
      block_ready = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_state", 128'(state_dbg), 128'd0);
      check("rst_block_out", block_out, 128'd0);
      check("rst_block_valid", 128'(block_valid), 128'd0);
      check("rst_byte_count", 128'(byte_count), 128'd0);
      check("rst_err", 128'(err), 128'd0);
      check("rst_bcd_ready", 128'(bcd_ready), 128'd1);

      // back-to-back full block, first accept on edge 1
      exp_q.push_back(exp_byte(to_bcd(0)));
      bcd_in    = to_bcd(0);
      bcd_valid = 1'b1;
      reset_n   = 1'b1;
      @(negedge clk);
      for (int i = 1; i < 16; i++) send(to_bcd(i * 17), 1'b1);
      n = 0;
      while (!block_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("full_edge", 128'(cyc), 128'd144);
      check("full_block", block_out, full_blk);
      check("full_count", 128'(byte_count), 128'd16);

      // backpressure: block held, bcd_valid still high
      for (int i = 0; i < 20; i++) begin
         check("hold_bcd_ready", 128'(bcd_ready), 128'd0);
         check("hold_block", block_out, full_blk);
         @(negedge clk);
      end
      block_ready = 1'b1;
      @(negedge clk);
      block_ready = 1'b0;
      bcd_valid   = 1'b0;
      check("ack_valid", 128'(block_valid), 128'd0);
      check("ack_count", 128'(byte_count), 128'd0);
      check("ack_block_kept", block_out, full_blk);

      // single byte 128: bcd_ready low for exactly 8 cycles
      send(12'h128, 1'b1);
      n = 0;
      while (!bcd_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      bcd_valid = 1'b0;
      check("b128_busy", 128'(n), 128'd8);
      check("b128_count", 128'(byte_count), 128'd1);
      check("b128_byte", 128'(block_out[7:0]), 128'h80);

      // 5 bytes stored, then flush together with bcd_valid
      send_wait(12'h042);
      send_wait(12'h999);
      send_wait(12'h300);
      send_wait(12'h007);
      check("pre_flush_count", 128'(byte_count), 128'd5);
      flush     = 1'b1;
      bcd_valid = 1'b1;
      bcd_in    = 12'h123;
      #1;
      check("flush_bcd_ready", 128'(bcd_ready), 128'd0);
      @(negedge clk);
      flush     = 1'b0;
      bcd_valid = 1'b0;
      check("flush_count", 128'(byte_count), 128'd0);
      check("flush_block", block_out, 128'd0);
      check("flush_state", 128'(state_dbg), 128'd0);

`ifdef AES_LOADER_RANGE_CHECK_EN
      send(12'h256, 1'b0);
      bcd_valid = 1'b0;
      check("rej256_err", 128'(err), 128'd1);
      check("rej256_count", 128'(byte_count), 128'd0);
      @(negedge clk);
      check("rej256_err_clear", 128'(err), 128'd0);
      send(12'h0A0, 1'b0);
      bcd_valid = 1'b0;
      check("rej0a0_err", 128'(err), 128'd1);
      check("rej0a0_count", 128'(byte_count), 128'd0);
      @(negedge clk);
      check("rej0a0_err_clear", 128'(err), 128'd0);
      send_wait(12'h255);
      check("acc255_byte", 128'(block_out[7:0]), 128'hFF);
      check("acc255_count", 128'(byte_count), 128'd1);
      check("acc255_err", 128'(err), 128'd0);
`else
      send_wait(12'h300);
      check("wrap300_byte", 128'(block_out[7:0]), 128'h2C);
      check("wrap300_count", 128'(byte_count), 128'd1);
      check("no_err", 128'(err), 128'd0);
`endif

      // reset in the middle of CONV (iter == 4)
      send(12'h099, 1'b1);
      bcd_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_state", 128'(state_dbg), 128'd0);
      check("mid_rst_block", block_out, 128'd0);
      check("mid_rst_count", 128'(byte_count), 128'd0);
      check("mid_rst_valid", 128'(block_valid), 128'd0);
      check("mid_rst_err", 128'(err), 128'd0);
      check("mid_rst_ready", 128'(bcd_ready), 128'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      send_wait(12'h173);
      check("post_rst_block", block_out, 128'h00000000000000000000000000000000AD);
      check("post_rst_count", 128'(byte_count), 128'd1);

      // random in-range bytes through the scoreboard
      for (int i = 0; i < 6; i++) begin
`ifdef AES_LOADER_RANGE_CHECK_EN
         b = to_bcd(int'($urandom_range(0, 255)));
`else
         b = to_bcd(int'($urandom_range(0, 999)));
`endif
         send_wait(b);
      end
      check("rand_count", 128'(byte_count), 128'd7);
      repeat (2) @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_bcd_block_loader.md
# aes_bcd_block_loader

Input-side companion to the display path: accepts decimal bytes as three BCD digits (as shown on HEX2..HEX0), converts each back to binary with a sequential reverse double-dabble, and packs 16 bytes into a 128-bit AES state/key block. The output block feeds the Encrypt/Decrypt cores in place of the hard-wired constants, using the same byte order (first byte lands in bits [127:120]).

## Interface
- BYTES, default 16: bytes per assembled block (16 gives 128 bits).
- ITER, default 8: reverse double-dabble iterations, one per result bit.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- bcd_in  input  12  {hundreds, tens, ones} digits, 4 bits each
- bcd_valid  input  1  bcd_in is valid this cycle
- bcd_ready  output  1  loader can accept a byte this cycle
- flush  input  1  discard the partial block; synchronous
- block_out  output  8*BYTES  assembled block
- block_valid  output  1  block_out is complete
- block_ready  input  1  consumer takes the block
- byte_count  output  5  bytes stored in the current block
- err  output  1  one-cycle pulse when a byte is rejected

## Operation
- States: IDLE, CONV, FULL.
- bcd_ready = (state==IDLE) && !flush. It is combinational.
- IDLE:
  - flush=1: byte_count <= 0, block_out <= 0, no byte accepted.
  - Else, when bcd_valid && bcd_ready: latch {bcd_in, 8'h00} into a 20-bit work register, iter <= 0, go to CONV.
- CONV, one iteration per cycle:
  - Shift the work register right by 1.
  - Then, in each 4-bit BCD digit, subtract 3 if the digit is >= 8.
  - The low 8 bits hold the result after ITER iterations.
  - On the edge where iter==ITER-1: block_out <= {block_out[8*BYTES-9:0], result}, byte_count++.
  - Then go to FULL if byte_count reaches BYTES, else IDLE.
  - flush is ignored in CONV.
- FULL: block_valid=1 and block_out holds stable.
  - When block_ready=1: block_valid <= 0, byte_count <= 0, go to IDLE. block_out keeps its old value until the next byte shifts in.
  - flush in FULL acts the same as block_ready.
- Reset mid-operation: all state is cleared immediately and the in-flight byte is lost.

## Timing
- Reset values: state IDLE, block_out 0, block_valid 0, byte_count 0, err 0, bcd_ready 1 (once reset_n=1 and flush=0).
- Accept at edge k. CONV runs edges k+1..k+ITER. The byte is stored and byte_count updated at edge k+ITER. bcd_ready returns high after edge k+ITER.
- Throughput: one byte per ITER+1 cycles (9 cycles by default).
- block_valid rises on the same edge that stores the 16th byte.
- block_valid && block_ready completes the handshake in one cycle. bcd_ready is high again in the next cycle.
- err is high for exactly the cycle after the rejecting accept edge.

## Configuration
- AES_LOADER_RANGE_CHECK_EN defined:
  - At accept, reject any digit > 9, and reject a decimal value > 255.
  - A rejected byte pulses err and stays in IDLE. Nothing is stored and byte_count is unchanged.
- Undefined:
  - No check is made and err is tied to 0.
  - Valid digits give result = value mod 256 (e.g. 300 stores 8'h2C).
  - Digits > 9 give an undefined byte.

## Test plan
- Reset, then send 000,017,034,051,068,085,102,119,136,153,170,187,204,221,238,255 with bcd_valid held high. Required response: block_valid rises on edge 144, block_out = 128'h00112233445566778899aabbccddeeff, byte_count=16.
- Single byte 128 (12'h128). Required response: byte_count=1 after 9 cycles, block_out[7:0]=8'h80, bcd_ready low for exactly 8 cycles.
- With AES_LOADER_RANGE_CHECK_EN: send 12'h256, 12'h0A0, then 12'h255. Required response: 256 and 0A0 each pulse err for one cycle with byte_count 0; 255 stores 8'hFF and byte_count becomes 1.
- Fill the block and hold block_ready=0 for 20 cycles while bcd_valid=1. Required response: bcd_ready stays 0 and block_out is stable. Raising block_ready clears block_valid and byte_count on the next edge.
- Store 5 bytes, then assert flush in IDLE together with bcd_valid. Required response: byte not accepted, byte_count=0, block_out=0.
- Drop reset_n to 0 in the middle of CONV (iter=4). Required response: all outputs return to their reset values immediately, and the next byte converts correctly from scratch.
